// File: rtl/pmc_code_loader_if.sv
// pmc_code_loader_if: command, stream and code-RAM write bundle for the PMC
// code loader.
//   master : CPU-side register block. It drives start/abort/base_addr/word_count
//            and the data_valid/data stream, and it observes the loader outputs.
//   slave  : the loader. It drives data_ready, the mem_* write port,
//            pmcc_rst_n, busy, done, error and checksum.
interface pmc_code_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic              data_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              pmcc_rst_n;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  modport master (
    output start, abort, base_addr, word_count, data_valid, data,
    input  data_ready, mem_we, mem_addr, mem_wdata, pmcc_rst_n, busy, done,
           error, checksum
  );

  modport slave (
    input  start, abort, base_addr, word_count, data_valid, data,
    output data_ready, mem_we, mem_addr, mem_wdata, pmcc_rst_n, busy, done,
           error, checksum
  );
endinterface

// File: rtl/pmc_code_loader.sv
// pmc_code_loader: writer side of the PMC coprocessor instruction path.
// It loads a program of word_count 32-bit words into the 1024-word code RAM,
// starting at base_addr. The coprocessor is held in reset (pmcc_rst_n low)
// from the accepted start until the load completes without error.
// Ports:
//   clk, rst : system clock; asynchronous active-high reset.
//   bus      : pmc_code_loader_if.slave. It carries the start/abort command,
//              the valid/ready word stream, the registered code-RAM write port
//              and the pmcc_rst_n/busy/done/error/checksum status outputs.
// Optional feature macro: PMC_LOADER_CHECKSUM_EN. When it is defined, the
// loader keeps a running modulo-2**DATA_W sum of the accepted words. When it
// is undefined, checksum is tied to zero.
module pmc_code_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  pmc_code_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FLUSH   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // RAM depth expressed in the widened range-check width
  localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [ADDR_W:0]   remaining_q,  remaining_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              pmcc_rst_n_q, pmcc_rst_n_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              error_q,      error_d;

  logic [ADDR_W+1:0] end_addr_s;
  logic              range_err_s;
  logic              data_ready_s;
  logic              accept_s;
  logic              start_ok_s;

  // The end address is computed two bits wider so that base+count cannot wrap
  assign end_addr_s   = {2'b00, bus.base_addr} + {1'b0, bus.word_count};
  assign range_err_s  = (end_addr_s > DEPTH);
  assign start_ok_s   = (state_q == IDLE) && bus.start;
  // Ready is combinational, so abort blocks acceptance in the same cycle
  assign data_ready_s = (state_q == LOAD) &&
                        (remaining_q != {(ADDR_W+1){1'b0}}) && !bus.abort;
  assign accept_s     = bus.data_valid && data_ready_s;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pmcc_rst_n_d = pmcc_rst_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d       = bus.base_addr;
          remaining_d  = bus.word_count;
          error_d      = range_err_s;
          pmcc_rst_n_d = 1'b0;
          if (range_err_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (bus.word_count == {(ADDR_W+1){1'b0}}) begin
            state_d = RELEASE;
            busy_d  = 1'b0;
          end else begin
            state_d = LOAD;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          error_d      = 1'b1;
          pmcc_rst_n_d = 1'b0;
        end else if (accept_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.data;
          addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          remaining_d = remaining_q - {{ADDR_W{1'b0}}, 1'b1};
          if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d = FLUSH;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FLUSH: begin
        // The final write is on mem_* during this cycle
        if (bus.abort) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          error_d      = 1'b1;
          pmcc_rst_n_d = 1'b0;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d      = IDLE;
        pmcc_rst_n_d = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        pmcc_rst_n_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      remaining_q  <= {(ADDR_W+1){1'b0}};
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      pmcc_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pmcc_rst_n_q <= pmcc_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

`ifdef PMC_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running sum: cleared on an accepted start, plus one add per accepted word
  always_comb begin
    checksum_d = checksum_q;
    if (start_ok_s) begin
      checksum_d = {DATA_W{1'b0}};
    end else if (accept_s) begin
      checksum_d = checksum_q + bus.data;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= {DATA_W{1'b0}};
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`else
  logic unused_start_ok_s;
  assign unused_start_ok_s = start_ok_s;
  assign bus.checksum      = {DATA_W{1'b0}};
`endif

  assign bus.data_ready = data_ready_s;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.pmcc_rst_n = pmcc_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_pmc_code_loader.sv
// tb_pmc_code_loader: directed self-checking bench for pmc_code_loader.
// Inputs are driven on the falling edge. A rising-edge monitor logs each
// acceptance, write and done pulse, tagged with the edge index.
// Timing of the logged edge indices:
//   - A word accepted at edge N is logged as N.
//   - Its write is visible after edge N, so it is logged at edge N+1.
//   - The done pulse is visible after edge N+2, so it is logged at N+3.
module tb_pmc_code_loader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef PMC_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  int                acc_cyc[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                wr_cyc[$];
  int                done_cyc[$];

  pmc_code_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pmc_code_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge-indexed log of acceptances, writes and done pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.data_valid && bus.data_ready) acc_cyc.push_back(cyc + 1);
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc + 1);
    end
    if (bus.done) done_cyc.push_back(cyc + 1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    bus.start      = 1'b1;
    bus.base_addr  = b;
    bus.word_count = n;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.data_valid = 1'b0; bus.data = '0;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.data_ready, bus.mem_we, bus.pmcc_rst_n, bus.busy, bus.done, bus.error} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
        {bus.data_ready, bus.mem_we, bus.pmcc_rst_n, bus.busy, bus.done, bus.error});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.checksum} !== {10'h000, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_bus: got addr %h wdata %h csum %h expected zeros",
        bus.mem_addr, bus.mem_wdata, bus.checksum);
    end
    rst = 1'b0;
    begin
      int w0;
      w0 = wr_addr.size();
      bus.data_valid = 1'b1; bus.data = 32'h1234_5678;
      repeat (5) tick();
      n_checks++;
      if ({bus.data_ready, bus.pmcc_rst_n, bus.busy} !== 3'b000) begin
        n_fail++; $display("FAIL idle_flags: got %b expected 000",
          {bus.data_ready, bus.pmcc_rst_n, bus.busy});
      end
      n_checks++;
      if (wr_addr.size() - w0 !== 0) begin
        n_fail++; $display("FAIL idle_writes: got %0d expected 0", wr_addr.size() - w0);
      end
      bus.data_valid = 1'b0;
    end
  endtask

  task automatic test_basic();
    int w0, a0, d0;
    logic [DATA_W-1:0] exp_w [3];
    exp_w[0] = 32'h0000_000A; exp_w[1] = 32'h0000_000B; exp_w[2] = 32'h0000_000C;
    w0 = wr_addr.size(); a0 = acc_cyc.size(); d0 = done_cyc.size();
    do_start(10'h010, 11'd3);
    n_checks++;
    if ({bus.busy, bus.pmcc_rst_n} !== 2'b10) begin
      n_fail++; $display("FAIL basic_busy: got busy,pmcc %b expected 10", {bus.busy, bus.pmcc_rst_n});
    end
    bus.data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data = exp_w[i];
      tick();
    end
    bus.data_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (wr_addr.size() - w0 !== 3 || acc_cyc.size() - a0 !== 3 || done_cyc.size() - d0 !== 1) begin
      n_fail++; $display("FAIL basic_counts: got wr %0d acc %0d done %0d expected 3 3 1",
        wr_addr.size() - w0, acc_cyc.size() - a0, done_cyc.size() - d0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr_addr[w0+i] !== 10'h010 + 10'(i) || wr_data[w0+i] !== exp_w[i]) begin
          n_fail++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i,
            wr_addr[w0+i], wr_data[w0+i], 10'h010 + 10'(i), exp_w[i]);
        end
        n_checks++;
        if (wr_cyc[w0+i] - acc_cyc[a0+i] !== 1) begin
          n_fail++; $display("FAIL basic_latency%0d: got %0d expected 1", i, wr_cyc[w0+i] - acc_cyc[a0+i]);
        end
      end
      n_checks++;
      if (wr_cyc[w0+2] - wr_cyc[w0] !== 2) begin
        n_fail++; $display("FAIL basic_consecutive: got span %0d expected 2", wr_cyc[w0+2] - wr_cyc[w0]);
      end
      n_checks++;
      if (done_cyc[d0] - acc_cyc[a0+2] !== 3) begin
        n_fail++; $display("FAIL basic_done_time: got %0d expected 3", done_cyc[d0] - acc_cyc[a0+2]);
      end
    end
    n_checks++;
    if ({bus.pmcc_rst_n, bus.busy, bus.error, bus.done} !== 4'b1000) begin
      n_fail++; $display("FAIL basic_final: got pmcc,busy,err,done %b expected 1000",
        {bus.pmcc_rst_n, bus.busy, bus.error, bus.done});
    end
    n_checks++;
    if (bus.checksum !== (CSUM_EN ? 32'h0000_0021 : 32'h0)) begin
      n_fail++; $display("FAIL basic_checksum: got %h expected %h", bus.checksum,
        (CSUM_EN ? 32'h0000_0021 : 32'h0));
    end
  endtask

  task automatic test_range();
    int w0, d0;
    w0 = wr_addr.size(); d0 = done_cyc.size();
    do_start(10'h3FF, 11'd2);
    n_checks++;
    if ({bus.error, bus.pmcc_rst_n, bus.busy} !== 3'b100) begin
      n_fail++; $display("FAIL range_flags: got err,pmcc,busy %b expected 100",
        {bus.error, bus.pmcc_rst_n, bus.busy});
    end
    bus.data_valid = 1'b1; bus.data = 32'h5555_AAAA;
    repeat (3) tick();
    n_checks++;
    if (bus.data_ready !== 1'b0 || wr_addr.size() - w0 !== 0 || done_cyc.size() - d0 !== 0) begin
      n_fail++; $display("FAIL range_idle: got ready %b writes %0d done %0d expected 0 0 0",
        bus.data_ready, wr_addr.size() - w0, done_cyc.size() - d0);
    end
    bus.data_valid = 1'b0;
    do_start(10'h3FF, 11'd1);
    n_checks++;
    if ({bus.error, bus.busy} !== 2'b01) begin
      n_fail++; $display("FAIL range_edge_start: got err,busy %b expected 01", {bus.error, bus.busy});
    end
    bus.data_valid = 1'b1; bus.data = 32'hDEAD_BEEF;
    tick();
    bus.data_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (wr_addr.size() - w0 !== 1 || done_cyc.size() - d0 !== 1) begin
      n_fail++; $display("FAIL range_edge_counts: got wr %0d done %0d expected 1 1",
        wr_addr.size() - w0, done_cyc.size() - d0);
    end else begin
      n_checks++;
      if (wr_addr[w0] !== 10'h3FF || wr_data[w0] !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL range_edge_write: got %h/%h expected 3ff/deadbeef", wr_addr[w0], wr_data[w0]);
      end
    end
    n_checks++;
    if ({bus.pmcc_rst_n, bus.error} !== 2'b10) begin
      n_fail++; $display("FAIL range_edge_final: got pmcc,err %b expected 10", {bus.pmcc_rst_n, bus.error});
    end
  endtask

  task automatic test_abort();
    int w0, d0;
    w0 = wr_addr.size(); d0 = done_cyc.size();
    do_start(10'h100, 11'd5);
    n_checks++;
    if (bus.pmcc_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL abort_hold: got pmcc %b expected 0", bus.pmcc_rst_n);
    end
    bus.data_valid = 1'b1; bus.data = 32'h11; tick();
    bus.data_valid = 1'b0; tick();
    bus.data_valid = 1'b1; bus.data = 32'h22; tick();
    bus.data = 32'h33; bus.abort = 1'b1;
    #1;
    n_checks++;
    if (bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_ready: got %b expected 0", bus.data_ready);
    end
    tick();
    bus.abort = 1'b0; bus.data_valid = 1'b0;
    n_checks++;
    if ({bus.error, bus.busy, bus.pmcc_rst_n} !== 3'b100) begin
      n_fail++; $display("FAIL abort_flags: got err,busy,pmcc %b expected 100",
        {bus.error, bus.busy, bus.pmcc_rst_n});
    end
    repeat (3) tick();
    n_checks++;
    if (wr_addr.size() - w0 !== 2 || done_cyc.size() - d0 !== 0) begin
      n_fail++; $display("FAIL abort_counts: got wr %0d done %0d expected 2 0",
        wr_addr.size() - w0, done_cyc.size() - d0);
    end else begin
      n_checks++;
      if ({wr_addr[w0], wr_addr[w0+1], wr_data[w0], wr_data[w0+1]} !== {10'h100, 10'h101, 32'h11, 32'h22}) begin
        n_fail++; $display("FAIL abort_writes: got %h %h %h %h expected 100 101 11 22",
          wr_addr[w0], wr_addr[w0+1], wr_data[w0], wr_data[w0+1]);
      end
    end
    n_checks++;
    if ({bus.error, bus.pmcc_rst_n} !== 2'b10) begin
      n_fail++; $display("FAIL abort_sticky: got err,pmcc %b expected 10", {bus.error, bus.pmcc_rst_n});
    end
  endtask

  task automatic test_zero();
    int w0, d0, s;
    w0 = wr_addr.size(); d0 = done_cyc.size(); s = cyc;
    do_start(10'h005, 11'd0);
    n_checks++;
    if ({bus.error, bus.busy, bus.pmcc_rst_n, bus.done} !== 4'b0000) begin
      n_fail++; $display("FAIL zero_first: got err,busy,pmcc,done %b expected 0000",
        {bus.error, bus.busy, bus.pmcc_rst_n, bus.done});
    end
    tick();
    n_checks++;
    if ({bus.done, bus.pmcc_rst_n} !== 2'b11) begin
      n_fail++; $display("FAIL zero_release: got done,pmcc %b expected 11", {bus.done, bus.pmcc_rst_n});
    end
    tick();
    n_checks++;
    if ({bus.done, bus.pmcc_rst_n} !== 2'b01) begin
      n_fail++; $display("FAIL zero_after: got done,pmcc %b expected 01", {bus.done, bus.pmcc_rst_n});
    end
    n_checks++;
    if (wr_addr.size() - w0 !== 0 || done_cyc.size() - d0 !== 1) begin
      n_fail++; $display("FAIL zero_counts: got wr %0d done %0d expected 0 1",
        wr_addr.size() - w0, done_cyc.size() - d0);
    end else begin
      n_checks++;
      if (done_cyc[d0] - s !== 3) begin
        n_fail++; $display("FAIL zero_done_time: got %0d expected 3", done_cyc[d0] - s);
      end
    end
    n_checks++;
    if (bus.checksum !== 32'h0) begin
      n_fail++; $display("FAIL zero_checksum: got %h expected 0", bus.checksum);
    end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    w0 = wr_addr.size(); d0 = done_cyc.size();
    do_start(10'h200, 11'd4);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data = 32'h100 + 32'(i);
      if (i == 1) begin
        bus.start = 1'b1; bus.base_addr = 10'h000; bus.word_count = 11'd1;
      end
      tick();
      bus.start = 1'b0;
    end
    bus.data_valid = 1'b0;
    tick();
    bus.start = 1'b1; bus.base_addr = 10'h000; bus.word_count = 11'd1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: got %b expected 1", bus.done);
    end
    repeat (3) tick();
    n_checks++;
    if (wr_addr.size() - w0 !== 4 || done_cyc.size() - d0 !== 1) begin
      n_fail++; $display("FAIL b2b_counts: got wr %0d done %0d expected 4 1",
        wr_addr.size() - w0, done_cyc.size() - d0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wr_addr[w0+i] !== 10'h200 + 10'(i) || wr_data[w0+i] !== 32'h100 + 32'(i)) begin
          n_fail++; $display("FAIL b2b_write%0d: got %h/%h expected %h/%h", i,
            wr_addr[w0+i], wr_data[w0+i], 10'h200 + 10'(i), 32'h100 + 32'(i));
        end
      end
    end
    n_checks++;
    if ({bus.pmcc_rst_n, bus.busy, bus.error} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_final: got pmcc,busy,err %b expected 100",
        {bus.pmcc_rst_n, bus.busy, bus.error});
    end
    n_checks++;
    if (bus.checksum !== (CSUM_EN ? 32'h0000_0406 : 32'h0)) begin
      n_fail++; $display("FAIL b2b_checksum: got %h expected %h", bus.checksum,
        (CSUM_EN ? 32'h0000_0406 : 32'h0));
    end
  endtask

  task automatic test_reset_midload();
    int w0, d0;
    do_start(10'h300, 11'd4);
    bus.data_valid = 1'b1; bus.data = 32'hAA; tick();
    bus.data = 32'hBB; tick();
    n_checks++;
    if ({bus.mem_we, bus.busy} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_pre: got we,busy %b expected 11", {bus.mem_we, bus.busy});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.data_ready, bus.mem_we, bus.pmcc_rst_n, bus.busy, bus.done, bus.error} !== 6'b000000 ||
        bus.mem_addr !== 10'h000 || bus.mem_wdata !== 32'h0 || bus.checksum !== 32'h0) begin
      n_fail++; $display("FAIL midrst_values: got flags %b addr %h wdata %h csum %h expected zeros",
        {bus.data_ready, bus.mem_we, bus.pmcc_rst_n, bus.busy, bus.done, bus.error},
        bus.mem_addr, bus.mem_wdata, bus.checksum);
    end
    bus.data_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    w0 = wr_addr.size(); d0 = done_cyc.size();
    do_start(10'h020, 11'd2);
    bus.data_valid = 1'b1; bus.data = 32'h7; tick();
    bus.data_valid = 1'b0; tick();
    bus.data_valid = 1'b1; bus.data = 32'h9; tick();
    bus.data_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (wr_addr.size() - w0 !== 2 || done_cyc.size() - d0 !== 1) begin
      n_fail++; $display("FAIL midrst_reload_counts: got wr %0d done %0d expected 2 1",
        wr_addr.size() - w0, done_cyc.size() - d0);
    end else begin
      n_checks++;
      if ({wr_addr[w0], wr_addr[w0+1], wr_data[w0], wr_data[w0+1]} !== {10'h020, 10'h021, 32'h7, 32'h9}) begin
        n_fail++; $display("FAIL midrst_reload_writes: got %h %h %h %h expected 020 021 7 9",
          wr_addr[w0], wr_addr[w0+1], wr_data[w0], wr_data[w0+1]);
      end
    end
    n_checks++;
    if ({bus.pmcc_rst_n, bus.error} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_reload_final: got pmcc,err %b expected 10", {bus.pmcc_rst_n, bus.error});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_abort();
    test_zero();
    test_back_to_back();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
